// File: rtl/router_pkt_reader_if.sv
// router_pkt_reader_if: FIFO read side, output byte stream and packet status of the packet reader.
interface router_pkt_reader_if #(parameter int CNT_W = 8);
  logic fifo_empty;
  logic [7:0] fifo_data;
  logic rd_en;
  logic out_valid;
  logic [7:0] out_data;
  logic out_sop;
  logic out_eop;
  logic out_ready;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;
  logic pkt_done;
  logic parity_err;
  logic [CNT_W-1:0] pkt_count;
  logic [CNT_W-1:0] err_count;
  modport master(
    input fifo_empty, fifo_data, out_ready,
    output rd_en, out_valid, out_data, out_sop, out_eop,
    output pkt_addr, pkt_len, pkt_done, parity_err, pkt_count, err_count
  );
  modport slave(
    output fifo_empty, fifo_data, out_ready,
    input rd_en, out_valid, out_data, out_sop, out_eop,
    input pkt_addr, pkt_len, pkt_done, parity_err, pkt_count, err_count
  );
endinterface

// File: rtl/router_pkt_reader.sv
// router_pkt_reader: reads header/payload/parity packets from a FIFO, forwards bytes through a 2-entry buffer and reports status.
module router_pkt_reader #(parameter int CNT_W = 8) (
  input logic clk,
  input logic rst,
  router_pkt_reader_if.master bus
);
  typedef enum logic [1:0] {HDR, PAYLOAD, PARITY} state_t;
  state_t state, state_n;
  logic inflight, cap, pop;
  logic [1:0] occ;
  logic [9:0] buf0, buf1, ent;
  logic [7:0] b, acc, acc_n;
  logic [5:0] rem, rem_n;
  assign b = bus.fifo_data;
  assign cap = inflight;
  assign pop = bus.out_valid && bus.out_ready;
  // Reading only when the buffer is guaranteed a free slot for the byte next cycle.
  assign bus.rd_en = !rst && !bus.fifo_empty && ({1'b0, occ} + {2'b0, inflight} <= 3'd1 + {2'b0, pop});
  assign bus.out_valid = occ != 2'd0;
  assign {bus.out_sop, bus.out_eop, bus.out_data} = buf0;
  assign ent = {state == HDR, state == PARITY, b};
  always_comb begin
    state_n = !cap ? state :
              state == HDR ? (b[7:2] != 6'd0 ? PAYLOAD : PARITY) :
              state == PAYLOAD ? (rem == 6'd1 ? PARITY : PAYLOAD) : HDR;
    acc_n = !cap ? acc : state == HDR ? b : state == PAYLOAD ? acc ^ b : acc;
    rem_n = !cap ? rem : state == HDR ? b[7:2] : state == PAYLOAD ? rem - 6'd1 : rem;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR;
      inflight <= 1'b0;
      occ <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
      acc <= '0;
      rem <= '0;
      bus.pkt_addr <= '0;
      bus.pkt_len <= '0;
      bus.pkt_done <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.pkt_count <= '0;
      bus.err_count <= '0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      rem <= rem_n;
      inflight <= bus.rd_en;
      occ <= occ + {1'b0, cap} - {1'b0, pop};
      if (cap && (occ == 2'd0 || (occ == 2'd1 && pop))) buf0 <= ent;
      else if (pop && occ == 2'd2) buf0 <= buf1;
      if (cap && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) buf1 <= ent;
      if (cap && state == HDR) {bus.pkt_len, bus.pkt_addr} <= b;
      bus.pkt_done <= cap && state == PARITY;
      bus.parity_err <= cap && state == PARITY && b != acc;
      if (cap && state == PARITY) bus.pkt_count <= bus.pkt_count + 1'b1;
      if (cap && state == PARITY && b != acc && bus.err_count != '1) bus.err_count <= bus.err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_router_pkt_reader.sv
// tb_router_pkt_reader: directed scenarios for the packet reader against a behavioural FIFO and output log.
module tb_router_pkt_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready = 1'b0;
  always #5 clk = ~clk;
  router_pkt_reader_if #(.CNT_W(8)) bus();
  router_pkt_reader #(.CNT_W(8)) dut(.clk(clk), .rst(rst), .bus(bus.master));
  logic [7:0] mem [0:4095];
  int wr_ptr = 0, rd_ptr = 0;
  logic rd_v = 1'b0;
  logic [7:0] rd_d = 8'h00;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  assign bus.fifo_data = rd_v ? rd_d : 8'hzz;
  assign bus.out_ready = ready;
  always @(posedge clk) begin
    rd_v <= bus.rd_en;
    if (bus.rd_en) begin
      rd_d <= mem[rd_ptr[11:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end
  int cyc = 0, n = 0, done_cnt = 0, err_cnt = 0, coin_cnt = 0;
  logic [9:0] log_e [0:4095];
  int log_c [0:4095];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst) begin
    if (bus.out_valid && ready) begin
      log_e[n[11:0]] <= {bus.out_sop, bus.out_eop, bus.out_data};
      log_c[n[11:0]] <= cyc;
      n <= n + 1;
    end
    if (bus.pkt_done) done_cnt <= done_cnt + 1;
    if (bus.parity_err) err_cnt <= err_cnt + 1;
    if (bus.parity_err && bus.pkt_done) coin_cnt <= coin_cnt + 1;
  end
  int checks = 0, fails = 0;
  task automatic push(input logic [7:0] v);
    mem[wr_ptr[11:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_done(input int target, input int budget, input string name);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      step(1);
      k++;
    end
    checks++;
    if (done_cnt < target) begin
      fails++;
      $display("FAIL %s_timeout: pkt_done count %0d, required %0d", name, done_cnt, target);
    end
    step(3);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks += 6;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    if (bus.rd_en !== 1'b0) begin fails++; $display("FAIL rst_rd_en: got %b want 0", bus.rd_en); end
    if (bus.out_data !== 8'h00) begin fails++; $display("FAIL rst_out_data: got %h want 00", bus.out_data); end
    if (bus.pkt_count !== 8'd0 || bus.err_count !== 8'd0) begin fails++; $display("FAIL rst_counts: got %0d/%0d want 0/0", bus.pkt_count, bus.err_count); end
    if (bus.pkt_len !== 6'd0 || bus.pkt_addr !== 2'd0) begin fails++; $display("FAIL rst_hdr: got len %0d addr %0d want 0/0", bus.pkt_len, bus.pkt_addr); end
    if (bus.pkt_done !== 1'b0 || bus.parity_err !== 1'b0) begin fails++; $display("FAIL rst_pulses: got %b%b want 00", bus.pkt_done, bus.parity_err); end
    rst = 1'b0;
    step(2);
  endtask
  task automatic test_good_packet();
    logic [7:0] pk [5];
    int base, d0, e0;
    pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    base = n; d0 = done_cnt; e0 = err_cnt;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) push(pk[i]);
    wait_done(d0 + 1, 40, "good");
    checks++;
    if (n - base !== 5) begin fails++; $display("FAIL good_nbytes: got %0d want 5", n - base); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_e[base+i] !== {i == 0, i == 4, pk[i]}) begin fails++; $display("FAIL good_byte%0d: got %h want %h", i, log_e[base+i], {i == 0, i == 4, pk[i]}); end
    end
    checks += 4;
    if (log_c[base+4] - log_c[base] !== 4) begin fails++; $display("FAIL good_consecutive: span %0d want 4", log_c[base+4] - log_c[base]); end
    if (bus.pkt_len !== 6'd3 || bus.pkt_addr !== 2'd1) begin fails++; $display("FAIL good_hdr: got len %0d addr %0d want 3/1", bus.pkt_len, bus.pkt_addr); end
    if (bus.pkt_count !== 8'd1 || bus.err_count !== 8'd0) begin fails++; $display("FAIL good_counts: got %0d/%0d want 1/0", bus.pkt_count, bus.err_count); end
    if (err_cnt !== e0) begin fails++; $display("FAIL good_parity_err: got %0d pulses want 0", err_cnt - e0); end
  endtask
  task automatic test_bad_parity();
    logic [7:0] pk [5];
    int base, d0, e0, c0;
    pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
    base = n; d0 = done_cnt; e0 = err_cnt; c0 = coin_cnt;
    for (int i = 0; i < 5; i++) push(pk[i]);
    wait_done(d0 + 1, 40, "bad");
    checks++;
    if (n - base !== 5) begin fails++; $display("FAIL bad_nbytes: got %0d want 5", n - base); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_e[base+i] !== {i == 0, i == 4, pk[i]}) begin fails++; $display("FAIL bad_byte%0d: got %h want %h", i, log_e[base+i], {i == 0, i == 4, pk[i]}); end
    end
    checks += 3;
    if (err_cnt - e0 !== 1) begin fails++; $display("FAIL bad_err_pulse: got %0d want 1", err_cnt - e0); end
    if (coin_cnt - c0 !== 1) begin fails++; $display("FAIL bad_coincident: got %0d want 1", coin_cnt - c0); end
    if (bus.err_count !== 8'd1 || bus.pkt_count !== 8'd2) begin fails++; $display("FAIL bad_counts: got %0d/%0d want 2/1", bus.pkt_count, bus.err_count); end
  endtask
  task automatic test_zero_len();
    int base, d0, e0;
    base = n; d0 = done_cnt; e0 = err_cnt;
    push(8'h02); push(8'h02);
    wait_done(d0 + 1, 30, "zero");
    checks += 5;
    if (n - base !== 2) begin fails++; $display("FAIL zero_nbytes: got %0d want 2", n - base); end
    if (log_e[base] !== 10'h202) begin fails++; $display("FAIL zero_hdr_byte: got %h want 202", log_e[base]); end
    if (log_e[base+1] !== 10'h102) begin fails++; $display("FAIL zero_par_byte: got %h want 102", log_e[base+1]); end
    if (bus.pkt_len !== 6'd0 || bus.pkt_addr !== 2'd2 || bus.pkt_count !== 8'd3) begin fails++; $display("FAIL zero_status: got len %0d addr %0d cnt %0d want 0/2/3", bus.pkt_len, bus.pkt_addr, bus.pkt_count); end
    if (err_cnt !== e0) begin fails++; $display("FAIL zero_parity_err: got %0d pulses want 0", err_cnt - e0); end
  endtask
  task automatic test_backpressure();
    logic [7:0] pk [5];
    int base, d0, rp0;
    pk = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    ready = 1'b0;
    base = n; d0 = done_cnt; rp0 = rd_ptr;
    for (int i = 0; i < 5; i++) push(pk[i]);
    step(3);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.out_valid, bus.out_sop, bus.out_data} !== 10'h30D) begin fails++; $display("FAIL bp_head_c%0d: got %h want 30D", i, {bus.out_valid, bus.out_sop, bus.out_data}); end
      step(1);
    end
    checks += 3;
    if (rd_ptr - rp0 !== 2) begin fails++; $display("FAIL bp_reads: got %0d want 2", rd_ptr - rp0); end
    if (bus.rd_en !== 1'b0) begin fails++; $display("FAIL bp_rd_en: got %b want 0", bus.rd_en); end
    if (dut.occ !== 2'd2) begin fails++; $display("FAIL bp_occ: got %0d want 2", dut.occ); end
    ready = 1'b1;
    wait_done(d0 + 1, 40, "bp");
    checks += 2;
    if (n - base !== 5) begin fails++; $display("FAIL bp_nbytes: got %0d want 5", n - base); end
    if (bus.pkt_count !== 8'd4) begin fails++; $display("FAIL bp_count: got %0d want 4", bus.pkt_count); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_e[base+i] !== {i == 0, i == 4, pk[i]}) begin fails++; $display("FAIL bp_byte%0d: got %h want %h", i, log_e[base+i], {i == 0, i == 4, pk[i]}); end
    end
  endtask
  task automatic test_reset_mid();
    int base, d0, e0;
    ready = 1'b1;
    push(8'h0D); push(8'h11);
    step(6);
    checks++;
    if (bus.pkt_len !== 6'd3) begin fails++; $display("FAIL mid_pre_len: got %0d want 3", bus.pkt_len); end
    rst = 1'b1;
    step(2);
    checks += 2;
    if (bus.pkt_count !== 8'd0 || bus.pkt_len !== 6'd0) begin fails++; $display("FAIL mid_rst_state: got cnt %0d len %0d want 0/0", bus.pkt_count, bus.pkt_len); end
    if (bus.out_valid !== 1'b0 || bus.rd_en !== 1'b0) begin fails++; $display("FAIL mid_rst_out: got valid %b rd_en %b want 0/0", bus.out_valid, bus.rd_en); end
    rst = 1'b0;
    step(1);
    base = n; d0 = done_cnt; e0 = err_cnt;
    push(8'h05); push(8'hAA); push(8'hAF);
    wait_done(d0 + 1, 30, "mid");
    checks += 5;
    if (n - base !== 3) begin fails++; $display("FAIL mid_nbytes: got %0d want 3", n - base); end
    if (log_e[base] !== 10'h205) begin fails++; $display("FAIL mid_first_sop: got %h want 205", log_e[base]); end
    if (log_e[base+2] !== 10'h1AF) begin fails++; $display("FAIL mid_last_eop: got %h want 1AF", log_e[base+2]); end
    if (bus.pkt_len !== 6'd1 || bus.pkt_addr !== 2'd1 || bus.pkt_count !== 8'd1) begin fails++; $display("FAIL mid_status: got len %0d addr %0d cnt %0d want 1/1/1", bus.pkt_len, bus.pkt_addr, bus.pkt_count); end
    if (err_cnt !== e0 || bus.err_count !== 8'd0) begin fails++; $display("FAIL mid_parity_err: got %0d pulses cnt %0d want 0/0", err_cnt - e0, bus.err_count); end
  endtask
  task automatic test_counters();
    int d0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    d0 = done_cnt;
    for (int i = 0; i < 256; i++) begin push(8'h02); push(8'h02); end
    wait_done(d0 + 256, 700, "wrap");
    checks += 2;
    if (bus.pkt_count !== 8'd0) begin fails++; $display("FAIL wrap_pkt_count: got %0d want 0", bus.pkt_count); end
    if (bus.err_count !== 8'd0) begin fails++; $display("FAIL wrap_err_count: got %0d want 0", bus.err_count); end
    for (int i = 0; i < 300; i++) begin push(8'h02); push(8'h03); end
    wait_done(d0 + 556, 800, "sat");
    checks += 2;
    if (bus.err_count !== 8'd255) begin fails++; $display("FAIL sat_err_count: got %0d want 255", bus.err_count); end
    if (bus.pkt_count !== 8'd44) begin fails++; $display("FAIL sat_pkt_count: got %0d want 44", bus.pkt_count); end
  endtask
  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    test_counters();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/router_pkt_reader.md
ROUTER_PKT_READER -- requirements
Module: router_pkt_reader

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of pkt_count and err_count.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-005 SHALL have port fifo_data  input  8  FIFO read data; valid exactly one cycle after a cycle with rd_en=1.
REQ-006 SHALL have port rd_en  output  1  FIFO read strobe.
REQ-007 SHALL have port out_valid  output  1  output byte valid.
REQ-008 SHALL have port out_data  output  8  output byte.
REQ-009 SHALL have port out_sop  output  1  out_data is a header byte.
REQ-010 SHALL have port out_eop  output  1  out_data is a parity byte.
REQ-011 SHALL have port out_ready  input  1  downstream accepts; a transfer (pop) occurs when out_valid=1 and out_ready=1.
REQ-012 SHALL have port pkt_addr  output  2  address field of the last header.
REQ-013 SHALL have port pkt_len  output  6  length field of the last header.
REQ-014 SHALL have port pkt_done  output  1  one-cycle pulse when a packet's parity byte is captured.
REQ-015 SHALL have port parity_err  output  1  one-cycle pulse, coincident with pkt_done, on parity mismatch.
REQ-016 SHALL have port pkt_count  output  CNT_W  completed packets; wraps modulo 2^CNT_W.
REQ-017 SHALL have port err_count  output  CNT_W  parity errors; saturates at all-ones.

Function
REQ-018 SHALL use the packet format: header {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte equal to the XOR of the header and all payload bytes.
REQ-019 SHALL register inflight = rd_en each cycle; fifo_data SHALL be captured only when inflight=1, and SHALL be ignored otherwise, including when undriven/Z.
REQ-020 SHALL hold a 2-entry in-order output buffer of {data, sop, eop}, with occupancy occ in 0..2.
REQ-021 SHALL drive rd_en = !fifo_empty && (occ + inflight - pop) <= 1, which sustains one byte per cycle while out_ready=1.
REQ-022 SHALL let the buffer accept a captured byte and a pop in the same cycle with net occ unchanged; occ SHALL never exceed 2 and SHALL never underflow.
REQ-023 SHALL drive out_valid = (occ != 0), with out_data/out_sop/out_eop taken from the buffer head and held stable while out_valid=1 and out_ready=0.
REQ-024 SHALL run a parse FSM on captured bytes with states HDR, PAYLOAD and PARITY.
REQ-025 HDR: SHALL tag the byte sop, load pkt_len and pkt_addr, set acc=byte and rem=len, then go to PAYLOAD if len!=0, else to PARITY.
REQ-026 PAYLOAD: SHALL set acc^=byte and rem-=1; when rem==1 before the decrement, SHALL go to PARITY.
REQ-027 PARITY: SHALL tag the byte eop and go to HDR.
REQ-027a PARITY (status): in the capture cycle +1, SHALL pulse pkt_done and increment pkt_count; if byte!=acc, SHALL also pulse parity_err and increment err_count.
REQ-028 SHALL leave the FSM state unchanged on cycles with no captured byte.
REQ-029 SHALL forward every byte (header, payload, parity) to the output, including bytes of packets with parity errors.
REQ-030 SHALL hold pkt_len and pkt_addr until the next header is captured.
REQ-031 SHALL give a latency of 2 cycles from an rd_en=1 cycle to out_valid=1 when the buffer is empty (1 cycle FIFO read + 1 cycle capture).

Reset
REQ-032 SHALL, when rst=1 at a clock edge, clear:
- rd_en, inflight, occ, out_valid, out_sop, out_eop, out_data=0
- pkt_done, parity_err, pkt_addr, pkt_len, pkt_count, err_count=0
- acc, rem=0; FSM=HDR
REQ-033 SHALL force rd_en=0 while rst=1, and SHALL discard a byte in flight when reset is asserted mid-packet.
REQ-034 SHALL parse the first byte captured after reset as a header.

Verification
REQ-035 SHALL cover: FIFO holds 0x0D,0x11,0x22,0x33,0x0D with out_ready=1 -> 5 consecutive out_valid cycles, sop on 0x0D(first), eop on 0x0D(last), pkt_done=1, parity_err=0, pkt_len=3, pkt_addr=1, pkt_count=1.
REQ-036 SHALL cover: same packet with parity byte 0x0C -> parity_err and pkt_done pulse together, err_count=1, and all 5 bytes forwarded.
REQ-037 SHALL cover: header 0x02 (len 0, addr 2) followed by parity 0x02 -> 2 bytes out, sop then eop, pkt_done=1, parity_err=0.
REQ-038 SHALL cover: out_ready=0 for 10 cycles with a non-empty FIFO -> occ=2, rd_en=0 after at most 2 reads, head byte stable; on out_ready=1, bytes arrive in order with none lost or duplicated.
REQ-039 SHALL cover: rst=1 after header+1 payload byte of a len-3 packet, then a fresh 0x05,0xAA,0xAF -> first post-reset byte flagged sop, pkt_len=1, pkt_addr=1, pkt_done=1, parity_err=0.
REQ-040 SHALL cover: 256 good packets with CNT_W=8 -> pkt_count wraps to 0; 300 bad packets -> err_count holds at 255.
